// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: state encoding, default limits and byte-enable helper
// shared by the memory bus arbiter files.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT      = 255;
    localparam int MAX_DATA_RUN_DEFAULT = 4;

    function automatic logic [3:0] bus_be(input logic write, input logic [3:0] sel);
        return write ? sel : 4'b1111;
    endfunction

endpackage

// File: rtl/mem_req_latch.sv
// mem_req_latch: per-port pending flag plus capture of the early request info.
// A strobe in the completing cycle is taken as the next access.
module mem_req_latch #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         strobe,
    input  logic [W-1:0] info,
    input  logic         clear,
    output logic         pend,
    output logic [W-1:0] info_out
);

    logic         pend_q, pend_d;
    logic [W-1:0] info_q, info_d;
    logic         load;

    always_comb begin
        load   = strobe & (~pend_q | clear);
        pend_d = load | (pend_q & ~clear);
        info_d = load ? info : info_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= 1'b0;
            info_q <= '0;
        end else begin
            pend_q <= pend_d;
            info_q <= info_d;
        end
    end

    assign pend     = pend_q;
    assign info_out = info_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one req/ack memory bus between the data port
// (priority, with a run limit) and instruction fetch, with ack timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT      = TIMEOUT_DEFAULT,
    parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        D_EarlyStrobe,
    input  logic [31:0] D_EarlyAddress,
    input  logic        D_EarlyWrite,
    input  logic [31:0] D_WriteData,
    input  logic [3:0]  D_ByteSelect,
    input  logic        D_Write,
    output logic        D_Stall,
    output logic [31:0] D_ReadData,
    output logic        D_Valid,
    input  logic        I_EarlyStrobe,
    input  logic [31:0] I_EarlyAddress,
    output logic        I_Stall,
    output logic [31:0] I_ReadData,
    output logic        I_Valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_error
);

    arb_state_e  state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [31:0] tmo_q, tmo_d;
    logic        d_pend, i_pend;
    logic [32:0] d_info;
    logic [31:0] i_addr;
    logic        busy, squash, ack_ok, timeout, done, contend, pick_i;

    mem_req_latch #(.W(33)) u_d_latch (
        .clock    (clock),
        .reset    (reset),
        .strobe   (D_EarlyStrobe),
        .info     ({D_EarlyWrite, D_EarlyAddress}),
        .clear    (D_Valid),
        .pend     (d_pend),
        .info_out (d_info)
    );

    mem_req_latch #(.W(32)) u_i_latch (
        .clock    (clock),
        .reset    (reset),
        .strobe   (I_EarlyStrobe),
        .info     (I_EarlyAddress),
        .clear    (I_Valid),
        .pend     (i_pend),
        .info_out (i_addr)
    );

    always_comb begin
        busy       = state_q == GRANT_D || state_q == GRANT_I;
        // A squashed store never reaches the bus and retires on its own.
        squash     = state_q == GRANT_D && d_info[32] && !D_Write;
        mem_req    = state_q == GRANT_I || (state_q == GRANT_D && !squash);
        ack_ok     = mem_req && mem_ack;
        timeout    = TIMEOUT != 0 && mem_req && !mem_ack && tmo_q == 32'(TIMEOUT - 1);
        done       = squash || ack_ok || timeout;
        D_Valid    = state_q == GRANT_D && done;
        I_Valid    = state_q == GRANT_I && done;
        D_ReadData = (state_q == GRANT_D && ack_ok) ? mem_rdata : '0;
        I_ReadData = (state_q == GRANT_I && ack_ok) ? mem_rdata : '0;
        bus_error  = timeout;
        D_Stall    = d_pend && !D_Valid;
        I_Stall    = i_pend && !I_Valid;
        mem_we     = mem_req && state_q == GRANT_D && d_info[32];
        mem_addr   = !mem_req ? '0 : state_q == GRANT_D ? d_info[31:0] : i_addr;
        mem_be     = !mem_req ? 4'b0000 : bus_be(mem_we, D_ByteSelect);
        mem_wdata  = (mem_req && state_q == GRANT_D) ? D_WriteData : '0;
        contend    = d_pend && i_pend;
        pick_i     = i_pend && (!d_pend || run_q == 8'(MAX_DATA_RUN));
        state_d    = !busy ? (pick_i ? GRANT_I : d_pend ? GRANT_D : IDLE) : done ? IDLE : state_q;
        run_d      = busy ? run_q : pick_i ? 8'd0 : d_pend ? (contend ? run_q + 8'd1 : 8'd0) : run_q;
        tmo_d      = !busy ? 32'd0 : mem_req ? tmo_q + 32'd1 : tmo_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios with literal expectations, plus a
// transaction-level model compared against every output each cycle.
module tb_mem_bus_arbiter;

    localparam int TMO = 8;
    localparam int MDR = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        D_EarlyStrobe = 1'b0, D_EarlyWrite = 1'b0, D_Write = 1'b0;
    logic [31:0] D_EarlyAddress = '0, D_WriteData = '0;
    logic [3:0]  D_ByteSelect = '0;
    logic        I_EarlyStrobe = 1'b0;
    logic [31:0] I_EarlyAddress = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        D_Stall, D_Valid, I_Stall, I_Valid, mem_req, mem_we, bus_error;
    logic [31:0] D_ReadData, I_ReadData, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.TIMEOUT(TMO), .MAX_DATA_RUN(MDR)) dut (
        .clock(clock), .reset(reset),
        .D_EarlyStrobe(D_EarlyStrobe), .D_EarlyAddress(D_EarlyAddress), .D_EarlyWrite(D_EarlyWrite),
        .D_WriteData(D_WriteData), .D_ByteSelect(D_ByteSelect), .D_Write(D_Write),
        .D_Stall(D_Stall), .D_ReadData(D_ReadData), .D_Valid(D_Valid),
        .I_EarlyStrobe(I_EarlyStrobe), .I_EarlyAddress(I_EarlyAddress),
        .I_Stall(I_Stall), .I_ReadData(I_ReadData), .I_Valid(I_Valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_error(bus_error)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: which port owns the bus (0 none, 1 D, 2 I) and for how many request cycles.
    logic        m_valid = 1'b0;
    int          m_own, m_age, m_run;
    logic        m_dpend, m_ipend, m_dwr;
    logic [31:0] m_daddr, m_iaddr;
    logic        sq, rq, to, fin, dclr, iclr;

    always @(negedge clock) begin
        if (m_valid) begin
            sq   = m_own == 1 && m_dwr && !D_Write;
            rq   = m_own != 0 && !sq;
            to   = rq && !mem_ack && (m_age + 1 == TMO);
            fin  = sq || (rq && (mem_ack || to));
            dclr = m_own == 1 && fin;
            iclr = m_own == 2 && fin;
            check("model_mem_req", mem_req, rq);
            check("model_mem_addr", mem_addr, !rq ? 32'h0 : m_own == 1 ? m_daddr : m_iaddr);
            check("model_mem_we", mem_we, rq && m_own == 1 && m_dwr);
            check("model_mem_be", mem_be, !rq ? 4'h0 : (m_own == 1 && m_dwr) ? D_ByteSelect : 4'hf);
            check("model_mem_wdata", mem_wdata, (rq && m_own == 1) ? D_WriteData : 32'h0);
            check("model_D_Valid", D_Valid, dclr);
            check("model_I_Valid", I_Valid, iclr);
            check("model_D_ReadData", D_ReadData, (m_own == 1 && rq && mem_ack) ? mem_rdata : 32'h0);
            check("model_I_ReadData", I_ReadData, (m_own == 2 && rq && mem_ack) ? mem_rdata : 32'h0);
            check("model_bus_error", bus_error, to);
            check("model_D_Stall", D_Stall, m_dpend && !dclr);
            check("model_I_Stall", I_Stall, m_ipend && !iclr);
            if (D_EarlyStrobe && m_dpend && !dclr) begin
                miscompares++;
                $display("FAIL illegal_d_strobe: strobe=1 while pending, required 0 at t=%0t", $time);
            end
            if (I_EarlyStrobe && m_ipend && !iclr) begin
                miscompares++;
                $display("FAIL illegal_i_strobe: strobe=1 while pending, required 0 at t=%0t", $time);
            end
        end
        if (reset) begin
            m_valid = 1'b1;
            m_own = 0; m_age = 0; m_run = 0;
            m_dpend = 1'b0; m_ipend = 1'b0; m_dwr = 1'b0;
            m_daddr = '0; m_iaddr = '0;
        end else if (m_valid) begin
            if (m_own == 0) begin
                if (m_dpend && m_ipend) begin
                    if (m_run == MDR) begin m_own = 2; m_run = 0; end
                    else begin m_own = 1; m_run++; end
                end else if (m_dpend) begin m_own = 1; m_run = 0; end
                else if (m_ipend) begin m_own = 2; m_run = 0; end
                m_age = 0;
            end else if (fin) m_own = 0;
            else if (rq) m_age++;
            if (D_EarlyStrobe && (!m_dpend || dclr)) begin
                m_dpend = 1'b1; m_daddr = D_EarlyAddress; m_dwr = D_EarlyWrite;
            end else if (dclr) m_dpend = 1'b0;
            if (I_EarlyStrobe && (!m_ipend || iclr)) begin
                m_ipend = 1'b1; m_iaddr = I_EarlyAddress;
            end else if (iclr) m_ipend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        D_EarlyStrobe = 0; D_EarlyWrite = 0; D_Write = 0; D_WriteData = '0; D_ByteSelect = '0;
        I_EarlyStrobe = 0; mem_ack = 0; mem_rdata = '0;
    endtask

    logic [5:0]  rd_req = 6'b011100, rd_stall = 6'b001110, rd_val = 6'b010000;
    logic [4:0]  sq_stall = 5'b00010, sq_val = 5'b00100;
    logic [11:0] to_req = 12'b0011_1111_1100, to_hit = 12'b0010_0000_0000;
    logic [8:0]  rs_req = 9'b001000100, rs_dst = 9'b000100110, rs_ist = 9'b000000110, rs_dv = 9'b001000000;
    int          order[16];
    int          exp_order[7] = '{1, 1, 1, 1, 2, 1, 2};
    int          n;

    initial begin
        idle_inputs();
        tick();
        tick();
        reset = 0;
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_stalls", {D_Stall, I_Stall, D_Valid, I_Valid, bus_error}, 0);
        tick();

        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            D_EarlyStrobe = c == 0; D_EarlyAddress = 32'h1000_0010;
            mem_ack = c == 4; mem_rdata = c == 4 ? 32'hDEAD_BEEF : 32'h0;
            #2;
            check("rd_req", mem_req, rd_req[c]);
            check("rd_stall", D_Stall, rd_stall[c]);
            check("rd_valid", D_Valid, rd_val[c]);
            if (c == 4) check("rd_data", D_ReadData, 32'hDEAD_BEEF);
            if (c == 3) check("rd_addr", mem_addr, 32'h1000_0010);
            tick();
        end
        idle_inputs();
        tick();

        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            D_EarlyStrobe = c == 0; D_EarlyAddress = 32'h1000_0022; D_EarlyWrite = c == 0;
            if (c >= 1 && c <= 4) begin
                D_Write = 1; D_WriteData = 32'h0000_BEEF; D_ByteSelect = 4'b0011;
            end
            mem_ack = c == 4;
            #2;
            if (c >= 2 && c <= 4) begin
                check("wr_we", mem_we, 1);
                check("wr_be", mem_be, 4'b0011);
                check("wr_wdata", mem_wdata, 32'h0000_BEEF);
                check("wr_addr", mem_addr, 32'h1000_0022);
            end
            check("wr_valid", D_Valid, c == 4);
            tick();
        end
        idle_inputs();
        tick();

        n = 0;
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            if (c == 0) begin
                D_EarlyStrobe = 1; D_EarlyAddress = 32'h2000_0000;
                I_EarlyStrobe = 1; I_EarlyAddress = 32'h0040_0000;
            end
            #1;
            if (mem_req) begin mem_ack = 1; mem_rdata = 32'hA000_0000 + 32'(c); end
            #1;
            if (D_Valid || I_Valid) begin
                if (n < 16) order[n] = D_Valid ? 1 : 2;
                n++;
                if (n < 6 && D_Valid) begin D_EarlyStrobe = 1; D_EarlyAddress = 32'h2000_0000 + 32'(4 * n); end
                if (n < 6 && I_Valid) begin I_EarlyStrobe = 1; I_EarlyAddress = 32'h0040_0000 + 32'(4 * n); end
            end
            tick();
        end
        check("arb_grant_count", n, 7);
        for (int k = 0; k < 7; k++) check($sformatf("arb_order_%0d", k), order[k], exp_order[k]);
        idle_inputs();
        tick();

        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            D_EarlyStrobe = c == 0; D_EarlyAddress = 32'h1000_0030; D_EarlyWrite = c == 0;
            if (c >= 1) begin D_WriteData = 32'h5555_5555; D_ByteSelect = 4'b1111; end
            mem_ack = c == 2; mem_rdata = 32'h99;
            #2;
            check("sq_req", mem_req, 0);
            check("sq_stall", D_Stall, sq_stall[c]);
            check("sq_valid", D_Valid, sq_val[c]);
            check("sq_rdata", D_ReadData, 0);
            tick();
        end
        idle_inputs();
        tick();

        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 12; c++) begin
                idle_inputs();
                I_EarlyStrobe = c == 0; I_EarlyAddress = 32'h0040_0100;
                mem_rdata = 32'h1234_5678;
                mem_ack = v == 1 && c == 9;
                #2;
                check("to_req", mem_req, to_req[c]);
                check("to_error", bus_error, v == 0 && to_hit[c]);
                check("to_valid", I_Valid, to_hit[c]);
                check("to_rdata", I_ReadData, (v == 1 && c == 9) ? 32'h1234_5678 : 32'h0);
                if (c >= 10) check("to_stall", I_Stall, 0);
                tick();
            end
        end
        idle_inputs();
        tick();

        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            D_EarlyStrobe = c == 0 || c == 4;
            D_EarlyAddress = c == 0 ? 32'h1000_0040 : 32'h1000_0050;
            I_EarlyStrobe = c == 0; I_EarlyAddress = 32'h0040_0200;
            reset = c == 2;
            mem_ack = c == 4 || c == 6; mem_rdata = c == 6 ? 32'hCAFE_F00D : 32'h0;
            #2;
            check("rs_req", mem_req, rs_req[c]);
            check("rs_dstall", D_Stall, rs_dst[c]);
            check("rs_istall", I_Stall, rs_ist[c]);
            check("rs_dvalid", D_Valid, rs_dv[c]);
            check("rs_ivalid", I_Valid, 0);
            if (c == 6) begin
                check("rs_addr", mem_addr, 32'h1000_0050);
                check("rs_rdata", D_ReadData, 32'hCAFE_F00D);
            end
            tick();
        end
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
